operand_collector: RTL and testbench

//  Parametrised successor to the fixed three-operand receive FSM.
//  - Collects a stream of DATA_W-bit read beats into NUM_NARROW narrow operands, then one wide operand of WIDE_BEATS beats.
//  - Presents the operand set to the execute stage with a valid/ready handshake.
//  - Adds input backpressure, output hold, zero-bubble back-to-back sets and a synchronous abort.
//  - Sits between the read-data path and the operation unit.

---
 rtl/operand_collector.sv | 101 ++++++++++
 tb/tb_operand_collector.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - collects read beats into narrow operands plus one wide operand
module operand_collector #(
    parameter int DATA_W     = 20,
    parameter int NUM_NARROW = 2,
    parameter int WIDE_BEATS = 2
) (
    input  logic                         clk,
    input  logic                         arst_ni,
    input  logic                         clear_i,
    input  logic                         rd_data_valid_i,
    output logic                         rd_data_ready_o,
    input  logic [DATA_W-1:0]            rd_data_i,
    output logic [NUM_NARROW*DATA_W-1:0] operands_o,
    output logic [WIDE_BEATS*DATA_W-1:0] operand_wide_o,
    output logic                         operation_valid_o,
    input  logic                         operation_ready_i
);

    localparam int TOTAL = NUM_NARROW + WIDE_BEATS;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    generate
        if (NUM_NARROW < 1 || WIDE_BEATS < 1) begin : g_param_check
            $error("operand_collector: NUM_NARROW and WIDE_BEATS must both be >= 1");
        end
    endgenerate

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // clear wins over everything, so a beat offered during clear is never taken
    assign accept = rd_data_valid_i & rd_data_ready_o & ~clear_i;

    // state register
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // next state: the last beat enters HOLD, a consumed set returns to COLLECT
    always_comb begin
        state_next = state;
        if (clear_i) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && cnt == LAST) state_next = HOLD;
                HOLD:    if (operation_ready_i)     state_next = COLLECT;
                default: state_next = COLLECT;
            endcase
        end
    end

    // outputs: a consumed set frees the input in the same cycle for a zero-bubble reload
    always_comb begin
        operation_valid_o = (state == HOLD);
        rd_data_ready_o   = (state == COLLECT) || (state == HOLD && operation_ready_i);
    end

    // beat counter; it is already 0 in HOLD, so a beat taken at hand-off becomes beat 0
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt <= '0;
        end else if (clear_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // operand registers: each accepted beat lands in the slice selected by cnt
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            operands_o     <= '0;
            operand_wide_o <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_NARROW; k++) begin
                if (cnt == CNT_W'(k)) begin
                    operands_o[k*DATA_W +: DATA_W] <= rd_data_i;
                end
            end
            for (int j = 0; j < WIDE_BEATS; j++) begin
                if (cnt == CNT_W'(NUM_NARROW + j)) begin
                    operand_wide_o[j*DATA_W +: DATA_W] <= rd_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_collector.sv
// tb/tb_operand_collector.sv - self-checking bench for operand_collector
module tb_operand_collector;

    localparam int DW_A = 20, NN_A = 2, WB_A = 2;
    localparam int DW_B = 8,  NN_B = 3, WB_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic                   clr_a, vld_a, rdy_a, rr_a, ov_a;
    logic [DW_A-1:0]        data_a;
    logic [NN_A*DW_A-1:0]   ops_a;
    logic [WB_A*DW_A-1:0]   wide_a;

    logic                   clr_b, vld_b, rdy_b, rr_b, ov_b;
    logic [DW_B-1:0]        data_b;
    logic [NN_B*DW_B-1:0]   ops_b;
    logic [WB_B*DW_B-1:0]   wide_b;

    operand_collector #(.DATA_W(DW_A), .NUM_NARROW(NN_A), .WIDE_BEATS(WB_A)) dut_a (
        .clk(clk), .arst_ni(rst_n), .clear_i(clr_a),
        .rd_data_valid_i(vld_a), .rd_data_ready_o(rr_a), .rd_data_i(data_a),
        .operands_o(ops_a), .operand_wide_o(wide_a),
        .operation_valid_o(ov_a), .operation_ready_i(rdy_a)
    );

    operand_collector #(.DATA_W(DW_B), .NUM_NARROW(NN_B), .WIDE_BEATS(WB_B)) dut_b (
        .clk(clk), .arst_ni(rst_n), .clear_i(clr_b),
        .rd_data_valid_i(vld_b), .rd_data_ready_o(rr_b), .rd_data_i(data_b),
        .operands_o(ops_b), .operand_wide_o(wide_b),
        .operation_valid_o(ov_b), .operation_ready_i(rdy_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sampled outputs of the selected DUT
    logic         s_rr, s_ov;
    logic [127:0] s_ops, s_wide;

    task automatic drive(input int sel, input bit clr, input bit vld, input logic [19:0] d, input bit rdy);
        if (sel == 0) begin
            clr_a = clr; vld_a = vld; data_a = d; rdy_a = rdy;
        end else begin
            clr_b = clr; vld_b = vld; data_b = d[7:0]; rdy_b = rdy;
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            s_rr = rr_a; s_ov = ov_a; s_ops = 128'(ops_a); s_wide = 128'(wide_a);
        end else begin
            s_rr = rr_b; s_ov = ov_b; s_ops = 128'(ops_b); s_wide = 128'(wide_b);
        end
    endtask

    // ---------------- reference model: queue of accepted beats ----------------
    int           nn, wb, dw;
    int unsigned  mq[$];
    bit           mvalid;
    logic [127:0] mops, mwide;

    task automatic model_reset();
        mq.delete();
        mvalid = 1'b0;
    endtask

    task automatic model_edge(input bit clr, input bit vld, input logic [19:0] d, input bit rdy);
        bit acc;
        if (clr) begin
            model_reset();
        end else begin
            acc = vld && (!mvalid || rdy);
            if (mvalid && rdy) mvalid = 1'b0;
            if (acc) begin
                mq.push_back(32'(d));
                if (mq.size() == nn + wb) begin
                    mops  = '0;
                    mwide = '0;
                    for (int k = 0; k < nn; k++) mops  = mops  | (128'(mq[k]) << (k * dw));
                    for (int j = 0; j < wb; j++) mwide = mwide | (128'(mq[nn + j]) << (j * dw));
                    mvalid = 1'b1;
                    mq.delete();
                end
            end
        end
    endtask

    task automatic step(input int sel, input bit clr, input bit vld, input logic [19:0] d, input bit rdy);
        drive(sel, clr, vld, d, rdy);
        #1;
        sample(sel);
        check($sformatf("dut%0d rd_ready", sel), 128'(s_rr), 128'(!mvalid || rdy));
        check($sformatf("dut%0d valid", sel), 128'(s_ov), 128'(mvalid));
        if (mvalid) begin
            check($sformatf("dut%0d operands", sel), s_ops, mops);
            check($sformatf("dut%0d wide", sel), s_wide, mwide);
        end
        @(posedge clk);
        model_edge(clr, vld, d, rdy);
        @(negedge clk);
    endtask

    // ---------------- directed vector table for the default DUT ----------------
    typedef struct {
        bit          clr;
        bit          vld;
        logic [19:0] data;
        bit          rdy;
        bit          ev;
        bit          err;
        bit          chk;
        logic [39:0] eops;
        logic [39:0] ewide;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit clr, input bit vld, input logic [19:0] data, input bit rdy,
                       input bit ev, input bit err, input bit chk,
                       input logic [39:0] eops, input logic [39:0] ewide);
        vec_t v;
        v.clr = clr; v.vld = vld; v.data = data; v.rdy = rdy;
        v.ev = ev; v.err = err; v.chk = chk; v.eops = eops; v.ewide = ewide;
        tbl.push_back(v);
    endtask

    localparam logic [39:0] OPS1 = 40'hDEADFABCDE, WIDE1 = 40'hFADEDCAFEA;
    localparam logic [39:0] OPS5 = 40'h2222211111, WIDE5 = 40'h4444433333;
    localparam logic [39:0] OPS6 = 40'h6666655555, WIDE6 = 40'h8888877777;

    logic [19:0] beats12 [12];
    logic [19:0] mask;
    int          pulses[$];

    task automatic burst12(input int sel);
        pulses.delete();
        for (int i = 0; i < 13; i++) begin
            step(sel, 1'b0, i < 12, (i < 12) ? (beats12[i] & mask) : 20'h0, 1'b1);
            if (s_ov) pulses.push_back(i);
        end
        check($sformatf("dut%0d burst pulse count", sel), 128'(pulses.size()), 128'(3));
        for (int p = 0; p < pulses.size() && p < 3; p++)
            check($sformatf("dut%0d burst pulse %0d cycle", sel, p), 128'(pulses[p]), 128'(4 * (p + 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        beats12 = '{20'hABCDE, 20'hDEADF, 20'hCAFEA, 20'hFADED, 20'hCBBDE, 20'hFADED,
                    20'h12345, 20'h6789A, 20'hBCDEF, 20'h01234, 20'h55AA5, 20'hA55AA};
        repeat (2) @(negedge clk);
        #1;
        sample(0);
        check("reset valid a", 128'(s_ov), 0);
        check("reset ops a", s_ops, 0);
        check("reset wide a", s_wide, 0);
        sample(1);
        check("reset valid b", 128'(s_ov), 0);
        check("reset ops b", s_ops, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sample(0);
        check("post-reset rd_ready a", 128'(s_rr), 1);
        @(negedge clk);

        // 1) four beats back-to-back, valid for exactly one cycle
        add(0, 1, 20'hABCDE, 1, 0, 1, 0, 0, 0);
        add(0, 1, 20'hDEADF, 1, 0, 1, 0, 0, 0);
        add(0, 1, 20'hCAFEA, 1, 0, 1, 0, 0, 0);
        add(0, 1, 20'hFADED, 1, 0, 1, 0, 0, 0);
        add(0, 0, 20'h0,     1, 1, 1, 1, OPS1, WIDE1);
        add(0, 0, 20'h0,     0, 0, 1, 0, 0, 0);
        // 2) hold for 5 cycles with an extra beat waiting
        add(0, 1, 20'hABCDE, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'hDEADF, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'hCAFEA, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'hFADED, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 20'hCBBDE, 0, 1, 0, 1, OPS1, WIDE1);
        add(0, 1, 20'hCBBDE, 1, 1, 1, 1, OPS1, WIDE1);
        add(0, 0, 20'h0,     0, 0, 1, 0, 0, 0);
        add(1, 1, 20'h12345, 0, 0, 1, 0, 0, 0);
        // 4) valid toggling; the beat offered under clear above must not appear
        add(0, 1, 20'hABCDE, 1, 0, 1, 0, 0, 0);
        add(0, 0, 20'h77777, 1, 0, 1, 0, 0, 0);
        add(0, 1, 20'hDEADF, 1, 0, 1, 0, 0, 0);
        add(0, 0, 20'h77777, 1, 0, 1, 0, 0, 0);
        add(0, 1, 20'hCAFEA, 1, 0, 1, 0, 0, 0);
        add(0, 0, 20'h77777, 1, 0, 1, 0, 0, 0);
        add(0, 1, 20'hFADED, 1, 0, 1, 0, 0, 0);
        add(0, 0, 20'h0,     1, 1, 1, 1, OPS1, WIDE1);
        add(0, 0, 20'h0,     1, 0, 1, 0, 0, 0);
        // 5) clear after two beats, then a fresh set
        add(0, 1, 20'h0AAAA, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h0BBBB, 0, 0, 1, 0, 0, 0);
        add(1, 0, 20'h0,     0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h11111, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h22222, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h33333, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h44444, 0, 0, 1, 0, 0, 0);
        add(0, 0, 20'h0,     0, 1, 0, 1, OPS5, WIDE5);
        add(0, 0, 20'h0,     1, 1, 1, 1, OPS5, WIDE5);
        add(0, 0, 20'h0,     0, 0, 1, 0, 0, 0);
        // clear while holding drops valid but keeps operand values
        add(0, 1, 20'h55555, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h66666, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h77777, 0, 0, 1, 0, 0, 0);
        add(0, 1, 20'h88888, 0, 0, 1, 0, 0, 0);
        add(1, 1, 20'h99999, 0, 1, 0, 1, OPS6, WIDE6);
        add(0, 0, 20'h0,     0, 0, 1, 1, OPS6, WIDE6);

        foreach (tbl[i]) begin
            drive(0, tbl[i].clr, tbl[i].vld, tbl[i].data, tbl[i].rdy);
            #1;
            sample(0);
            check($sformatf("vec%0d rd_ready", i), 128'(s_rr), 128'(tbl[i].err));
            check($sformatf("vec%0d valid", i), 128'(s_ov), 128'(tbl[i].ev));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d operands", i), s_ops, 128'(tbl[i].eops));
                check($sformatf("vec%0d wide", i), s_wide, 128'(tbl[i].ewide));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // default DUT against the model
        nn = NN_A; wb = WB_A; dw = DW_A; mask = 20'hFFFFF;
        model_reset();
        step(0, 1, 0, 0, 0);
        burst12(0);
        for (int n = 0; n < 600; n++)
            step(0, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
                 20'($urandom) & mask, $urandom_range(0, 99) < 60);

        // 6) asynchronous reset mid-set and mid-hold
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 20'hAAAAA, 0);
        step(0, 0, 1, 20'hBBBBB, 0);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        sample(0);
        check("reset mid-set valid", 128'(s_ov), 0);
        check("reset mid-set ops", s_ops, 0);
        check("reset mid-set wide", s_wide, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 20'h13579, 0);
        step(0, 0, 1, 20'h2468A, 0);
        step(0, 0, 1, 20'h3579B, 0);
        step(0, 0, 1, 20'h468AC, 0);
        step(0, 0, 0, 0, 0);
        check("post-reset set ops", s_ops, 128'(40'h2468A13579));
        check("post-reset set wide", s_wide, 128'(40'h468AC3579B));
        rst_n = 1'b0;
        #1;
        sample(0);
        check("reset mid-hold valid", 128'(s_ov), 0);
        check("reset mid-hold ops", s_ops, 0);
        check("reset mid-hold wide", s_wide, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 1, 20'h10101 * 20'(i + 1), 1);
        step(0, 0, 0, 0, 1);

        // narrow-heavy configuration: 3 narrow operands, 1 wide beat, 8-bit data
        nn = NN_B; wb = WB_B; dw = DW_B; mask = 20'h000FF;
        model_reset();
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 20'hAB, 1);
        step(1, 0, 1, 20'hCD, 1);
        step(1, 0, 1, 20'hEF, 1);
        step(1, 0, 1, 20'h12, 1);
        step(1, 0, 0, 0, 1);
        check("dut1 set ops", s_ops, 128'(24'hEFCDAB));
        check("dut1 set wide", s_wide, 128'(8'h12));
        check("dut1 set valid", 128'(s_ov), 1);
        burst12(1);
        for (int n = 0; n < 400; n++)
            step(1, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
                 20'($urandom) & mask, $urandom_range(0, 99) < 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
